// File: rtl/dcache_responder_if.sv
// Request/response bus between a data-cache initiator and the responder.
interface dcache_responder_if;
  logic        reqcyc;
  logic [0:63] req;
  logic [0:12] reqtag;
  logic        reqack;
  logic        respcyc;
  logic [0:63] resp;
  logic [0:12] resptag;
  logic        respack;

  modport master (
    output reqcyc, req, reqtag, respack,
    input  reqack, respcyc, resp, resptag
  );

  modport slave (
    input  reqcyc, req, reqtag, respack,
    output reqack, respcyc, resp, resptag
  );
endinterface

// File: rtl/dcache_responder.sv
// Single-outstanding data-cache responder backed by a DEPTH x 64-bit array.
// A request is acknowledged once per beat (address, then write data for
// writes), waits LATENCY cycles, then holds its response until respack.
module dcache_responder #(
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned LATENCY = 2
) (
  input logic              clk,
  input logic              reset,
  dcache_responder_if.slave bus
);

  localparam int unsigned IdxW = $clog2(DEPTH);
  localparam int unsigned CntW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CntW-1:0] CntInit = CntW'(LATENCY - 1);

  typedef enum logic [2:0] {StIdle, StAck, StWdata, StWait, StResp} stateT;

  stateT            stateQ, stateD;
  logic [CntW-1:0]  cntQ, cntD;
  logic             beatQ, beatD;
  logic [IdxW-1:0]  idxQ, idxD;
  logic [0:63]      dataQ, dataD;
  logic [0:12]      tagQ, tagD;
  logic             respcycQ, respcycD;
  logic [0:63]      respQ, respD;
  logic             memWe;

  logic [63:0] mem [DEPTH];

  // Next-state and datapath decisions; array access happens on the WAIT->RESP edge.
  always_comb begin
    stateD   = stateQ;
    cntD     = cntQ;
    beatD    = beatQ;
    idxD     = idxQ;
    dataD    = dataQ;
    tagD     = tagQ;
    respcycD = respcycQ;
    respD    = respQ;
    memWe    = 1'b0;
    case (stateQ)
      StIdle: begin
        if (bus.reqcyc) begin
          // Only the word index is kept: byte offset dropped, high bits wrap.
          idxD   = bus.req[61-IdxW:60];
          tagD   = bus.reqtag;
          beatD  = 1'b0;
          stateD = StAck;
        end
      end
      StAck: begin
        if (!tagQ[0] && !beatQ) begin
          stateD = StWdata;
        end else begin
          stateD = StWait;
          cntD   = CntInit;
        end
      end
      StWdata: begin
        if (bus.reqcyc) begin
          dataD  = bus.req;
          beatD  = 1'b1;
          stateD = StAck;
        end
      end
      StWait: begin
        if (cntQ == '0) begin
          stateD   = StResp;
          respcycD = 1'b1;
          respD    = (tagQ[1] && tagQ[0]) ? mem[idxQ] : '0;
          memWe    = tagQ[1] && !tagQ[0];
        end else begin
          cntD = cntQ - 1'b1;
        end
      end
      StResp: begin
        if (respcycQ && bus.respack) begin
          stateD   = StIdle;
          respcycD = 1'b0;
        end
      end
      default: stateD = StIdle;
    endcase
  end

  // State register with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stateQ   <= StIdle;
      cntQ     <= '0;
      beatQ    <= 1'b0;
      idxQ     <= '0;
      dataQ    <= '0;
      tagQ     <= '0;
      respcycQ <= 1'b0;
      respQ    <= '0;
    end else begin
      stateQ   <= stateD;
      cntQ     <= cntD;
      beatQ    <= beatD;
      idxQ     <= idxD;
      dataQ    <= dataD;
      tagQ     <= tagD;
      respcycQ <= respcycD;
      respQ    <= respD;
    end
  end

  // Backing array write; not reset, and suppressed while reset is asserted.
  always_ff @(posedge clk) begin
    if (memWe && !reset) begin
      mem[idxQ] <= dataQ;
    end
  end

  assign bus.reqack  = (stateQ == StAck);
  assign bus.respcyc = respcycQ;
  assign bus.resp    = respQ;
  assign bus.resptag = tagQ;

endmodule

// File: tb/tb_dcache_responder.sv
// Directed bench for dcache_responder (DEPTH=16, LATENCY=2).
module tb_dcache_responder;

  localparam int unsigned Depth = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  dcache_responder_if bus ();

  dcache_responder #(.DEPTH(Depth), .LATENCY(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [0:12] mkTag(input bit rd, input bit memSel);
    logic [0:12] t;
    t    = '0;
    t[0] = rd;
    t[1] = memSel;
    t[2] = 1'b1;
    t[7] = 1'b1;
    return t;
  endfunction

  // Runs one transaction; positions are negedge counts after reqcyc is raised.
  task automatic doTxn(input logic [0:12] t, input logic [0:63] addr, input logic [0:63] wdata,
                       input int hold, input bit keepAck,
                       output logic [0:63] rdata, output logic [0:12] rtag,
                       output int acks, output int respAt, output bit stable,
                       output bit dropped);
    int n;
    bus.reqcyc = 1'b1;
    bus.req    = addr;
    bus.reqtag = t;
    acks = 0; respAt = -1; n = 0; stable = 1'b1; dropped = 1'b0;
    rdata = '0; rtag = '0;
    while (respAt < 0 && n < 100) begin
      @(negedge clk);
      n++;
      if (bus.reqack) begin
        acks++;
        if (!t[0] && acks == 1) bus.req = wdata;
        else bus.reqcyc = 1'b0;
      end
      if (bus.respcyc) respAt = n;
    end
    bus.reqcyc = 1'b0;
    checkVal("resp_seen", 64'(respAt >= 0), 64'd1);
    if (respAt < 0) return;
    rdata = bus.resp;
    rtag  = bus.resptag;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (!bus.respcyc || bus.resp !== rdata || bus.resptag !== rtag) stable = 1'b0;
    end
    bus.respack = 1'b1;
    @(negedge clk);
    dropped = !bus.respcyc;
    if (!keepAck) bus.respack = 1'b0;
  endtask

  task automatic waitAck(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (bus.reqack) seen = 1'b1;
    end
  endtask

  task automatic checkZeroOutputs(input string tag);
    checkVal({tag, "_reqack"}, 64'(bus.reqack), 64'd0);
    checkVal({tag, "_respcyc"}, 64'(bus.respcyc), 64'd0);
    checkVal({tag, "_resp"}, 64'(bus.resp), 64'd0);
    checkVal({tag, "_resptag"}, 64'(bus.resptag), 64'd0);
  endtask

  initial begin
    logic [0:63] rd;
    logic [0:12] rt;
    int acks, respAt;
    bit stable, dropped, seen;
    logic [63:0] d1, d2;
    d1 = 64'hDEADBEEF_00000001;
    d2 = 64'h0123_4567_89AB_CDEF;

    bus.reqcyc = 1'b0; bus.req = '0; bus.reqtag = '0; bus.respack = 1'b0;
    repeat (2) @(negedge clk);
    checkZeroOutputs("reset");
    reset = 1'b0;
    @(negedge clk);

    // Memory write then read-back of 0x40.
    doTxn(mkTag(0, 1), 64'h40, d1, 1, 1'b0, rd, rt, acks, respAt, stable, dropped);
    checkVal("wr_acks", 64'(acks), 64'd2);
    checkVal("wr_resp", rd, 64'd0);
    checkVal("wr_tag", 64'(rt), 64'(mkTag(0, 1)));
    checkVal("wr_latency", 64'(respAt), 64'd6);
    checkVal("wr_drop", 64'(dropped), 64'd1);

    doTxn(mkTag(1, 1), 64'h40, '0, 0, 1'b0, rd, rt, acks, respAt, stable, dropped);
    checkVal("rd_data", rd, d1);
    checkVal("rd_acks", 64'(acks), 64'd1);
    checkVal("rd_latency", 64'(respAt), 64'd4);
    checkVal("rd_tag", 64'(rt), 64'(mkTag(1, 1)));

    // Low-bit and wrap aliasing onto index 8; write via wrapped 0xC8 hits index 9.
    doTxn(mkTag(1, 1), 64'h47, '0, 0, 1'b0, rd, rt, acks, respAt, stable, dropped);
    checkVal("rd_lowbits", rd, d1);
    doTxn(mkTag(1, 1), 64'h40 + Depth * 8, '0, 0, 1'b0, rd, rt, acks, respAt, stable, dropped);
    checkVal("rd_wrap", rd, d1);
    doTxn(mkTag(0, 1), 64'hC8, d2, 0, 1'b0, rd, rt, acks, respAt, stable, dropped);
    doTxn(mkTag(1, 1), 64'h48, '0, 0, 1'b0, rd, rt, acks, respAt, stable, dropped);
    checkVal("wr_wrap", rd, d2);

    // MMIO must not touch the array and returns zero.
    doTxn(mkTag(0, 0), 64'h40, 64'h1234, 0, 1'b0, rd, rt, acks, respAt, stable, dropped);
    checkVal("mmio_wr_resp", rd, 64'd0);
    checkVal("mmio_wr_acks", 64'(acks), 64'd2);
    doTxn(mkTag(1, 0), 64'h40, '0, 0, 1'b0, rd, rt, acks, respAt, stable, dropped);
    checkVal("mmio_rd_resp", rd, 64'd0);
    doTxn(mkTag(1, 1), 64'h40, '0, 0, 1'b0, rd, rt, acks, respAt, stable, dropped);
    checkVal("mmio_untouched", rd, d1);

    // Response held stable for 10 cycles without respack.
    doTxn(mkTag(1, 1), 64'h48, '0, 10, 1'b1, rd, rt, acks, respAt, stable, dropped);
    checkVal("hold_stable", 64'(stable), 64'd1);
    checkVal("hold_data", rd, d2);
    checkVal("hold_drop", 64'(dropped), 64'd1);

    // respack left high while idle has no effect.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkVal("idle_ack_respcyc", 64'(bus.respcyc), 64'd0);
      checkVal("idle_ack_reqack", 64'(bus.reqack), 64'd0);
    end
    doTxn(mkTag(1, 1), 64'h40, '0, 0, 1'b0, rd, rt, acks, respAt, stable, dropped);
    checkVal("preack_data", rd, d1);
    checkVal("preack_latency", 64'(respAt), 64'd4);
    checkVal("preack_drop", 64'(dropped), 64'd1);

    // Reset while parked in WDATA.
    bus.reqcyc = 1'b1; bus.req = 64'h40; bus.reqtag = mkTag(0, 1);
    waitAck(seen);
    checkVal("rst_wdata_ack", 64'(seen), 64'd1);
    bus.reqcyc = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    checkZeroOutputs("rst_wdata");
    @(negedge clk);
    reset = 1'b0;
    doTxn(mkTag(1, 1), 64'h40, '0, 0, 1'b0, rd, rt, acks, respAt, stable, dropped);
    checkVal("rst_wdata_keep", rd, d1);
    checkVal("rst_wdata_latency", 64'(respAt), 64'd4);

    // Reset in WAIT after both write beats.
    bus.reqcyc = 1'b1; bus.req = 64'h40; bus.reqtag = mkTag(0, 1);
    waitAck(seen);
    bus.req = 64'hBAD0_BAD0_BAD0_BAD0;
    waitAck(seen);
    checkVal("rst_wait_ack2", 64'(seen), 64'd1);
    bus.reqcyc = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    checkZeroOutputs("rst_wait");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    doTxn(mkTag(1, 1), 64'h40, '0, 0, 1'b0, rd, rt, acks, respAt, stable, dropped);
    checkVal("rst_wait_keep", rd, d1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got 1 expected 0");
    $fatal(1, "timeout");
  end

endmodule
